counter_bank_sc_module: RTL and testbench

//  Multi-channel programmable counter bank; parametrised successor to the single 8-bit enable counter.
//  NUM_CH independent channels share one prescaler. Each channel has up/down, load, clear and a

---
 rtl/counter_bank_pkg.sv | 19 +
 rtl/counter_bank_channel.sv | 120 ++++++++++++
 rtl/counter_bank_sc_module.sv | 70 +++++++
 tb/tb_counter_bank_sc_module.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg
//   Shared types for the counter bank: per-channel counting mode and
//   per-channel FSM state encodings.
package counter_bank_pkg;

    typedef enum logic [1:0] {
        CM_WRAP    = 2'b00,
        CM_SAT     = 2'b01,
        CM_ONESHOT = 2'b10,
        CM_RSVD    = 2'b11   // treated as wrap
    } ch_mode_e;

    typedef enum logic [1:0] {
        CS_IDLE = 2'b00,
        CS_RUN  = 2'b01,
        CS_DONE = 2'b10
    } ch_state_e;

endpackage

// File: rtl/counter_bank_channel.sv
// counter_bank_channel
//   One counter channel: FSM, count register and terminal-count pulse.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | count held at 0, waiting for load or enable
//   RUN     | counting on en && tick according to mode
//   DONE    | one-shot reached terminal value; count held, steps ignored
//
// Ports
//   clk, reset        clock, async active-high reset
//   tick              shared prescaler tick
//   en, up, clr, load per-channel controls (clr > load > step)
//   load_val          value loaded on load
//   mode              00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   q, tc, busy       registered count, 1-cycle terminal pulse, RUN flag
module counter_bank_channel
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
);

    ch_state_e        state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] stepped;
    ch_mode_e         mode_e;

    always_comb begin
        // Terminal value follows the live direction input.
        term    = up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        stepped = up ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
        mode_e  = ch_mode_e'(mode);

        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;

        if (clr) begin
            state_d = CS_IDLE;
            cnt_d   = '0;
        end else if (load) begin
            state_d = CS_RUN;
            cnt_d   = load_val;
        end else begin
            case (state_q)
                CS_IDLE: begin
                    cnt_d = '0;
                    // Entering RUN via enable does not step on the same edge.
                    if (en) begin
                        state_d = CS_RUN;
                    end
                end
                CS_RUN: begin
                    if (en && tick) begin
                        case (mode_e)
                            CM_SAT: begin
                                // Holding at the terminal value is not a new arrival.
                                if (cnt_q != term) begin
                                    cnt_d = stepped;
                                    tc_d  = (stepped == term);
                                end
                            end
                            CM_ONESHOT: begin
                                cnt_d = stepped;
                                if (stepped == term) begin
                                    tc_d    = 1'b1;
                                    state_d = CS_DONE;
                                end
                            end
                            default: begin
                                cnt_d = stepped;
                                tc_d  = (stepped == term);
                            end
                        endcase
                    end
                end
                CS_DONE: begin
                    state_d = CS_DONE;
                end
                default: begin
                    state_d = CS_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CS_IDLE;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
        end
    end

    assign q    = cnt_q;
    assign tc   = tc_q;
    assign busy = (state_q == CS_RUN);

endmodule

// File: rtl/counter_bank_sc_module.sv
// counter_bank_sc_module
//   Bank of NUM_CH independent programmable counters sharing one prescaler.
//
// Ports
//   clk, reset   clock, async active-high reset
//   div          prescaler divide: tick every div+1 cycles
//   en, up       per-channel enable and direction
//   clr, load    per-channel synchronous clear and load strobe
//   load_val     load values, channel i at [i*WIDTH +: WIDTH]
//   mode         per-channel mode, channel i at [2*i +: 2]
//   q            registered counts, channel i at [i*WIDTH +: WIDTH]
//   tc, busy     per-channel terminal-count pulse and RUN flag
module counter_bank_sc_module
    import counter_bank_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PRESCALE_W-1:0]   div,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       up,
    input  logic [NUM_CH-1:0]       clr,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    input  logic [2*NUM_CH-1:0]     mode,
    output logic [NUM_CH*WIDTH-1:0] q,
    output logic [NUM_CH-1:0]       tc,
    output logic [NUM_CH-1:0]       busy
);

    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic                  tick;

    // >= rather than == so lowering div below the running count ticks at once.
    always_comb begin
        tick      = (pre_cnt_q >= div);
        pre_cnt_d = tick ? '0 : pre_cnt_q + PRESCALE_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        counter_bank_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .en       (en[i]),
            .up       (up[i]),
            .clr      (clr[i]),
            .load     (load[i]),
            .load_val (load_val[i*WIDTH +: WIDTH]),
            .mode     (mode[2*i +: 2]),
            .q        (q[i*WIDTH +: WIDTH]),
            .tc       (tc[i]),
            .busy     (busy[i])
        );
    end

endmodule

// File: tb/tb_counter_bank_sc_module.sv
module tb_counter_bank_sc_module;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  div;
    logic [3:0]  en, up, clr, load;
    logic [31:0] load_val;
    logic [7:0]  mode;
    logic [31:0] q;
    logic [3:0]  tc, busy;

    int n_cmp = 0;
    int n_bad = 0;

    counter_bank_sc_module #(
        .NUM_CH     (4),
        .WIDTH      (8),
        .PRESCALE_W (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .div      (div),
        .en       (en),
        .up       (up),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .q        (q),
        .tc       (tc),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; div = 8'd0; en = '0; up = '0; clr = '0; load = '0;
        load_val = '0; mode = '0;
        #1;
        n_cmp++;
        if (q !== 32'h0 || tc !== 4'h0 || busy !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_init: q=%h tc=%b busy=%b, required q=0 tc=0 busy=0", q, tc, busy);
        end
        #11 reset = 1'b0;
        // Bring ch0 to 0x37 and let it step once.
        load_val[7:0] = 8'h37; load[0] = 1'b1; en[0] = 1'b1; up[0] = 1'b1;
        cyc();
        n_cmp++;
        if (q[7:0] !== 8'h37 || busy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_load37: q0=%h busy0=%b, required q0=37 busy0=1", q[7:0], busy[0]);
        end
        load[0] = 1'b0;
        cyc();
        n_cmp++;
        if (q[7:0] !== 8'h38) begin
            n_bad++;
            $display("FAIL reset_step38: q0=%h, required q0=38", q[7:0]);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (q !== 32'h0 || tc !== 4'h0 || busy !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_async: q=%h tc=%b busy=%b, required q=0 tc=0 busy=0", q, tc, busy);
        end
        #1 reset = 1'b0;
        en = '0; up = '0;
    endtask

    task automatic test_wrap_div();
        logic       found;
        logic       ok;
        logic [7:0] eq;
        logic       etc;
        div = 8'd2; mode[1:0] = 2'b00; up[0] = 1'b1; en[0] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc();
            if (q[7:0] == 8'h01) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL wrap_first_step: q0=%h after 10 cycles, required q0=01", q[7:0]);
        end
        ok = found;
        for (int v = 2; v <= 256 && ok; v++) begin
            for (int k = 1; k <= 3 && ok; k++) begin
                cyc();
                eq  = (k == 3) ? 8'(v) : 8'(v - 1);
                etc = (k == 3) && (v == 255);
                n_cmp++;
                if (q[7:0] !== eq || tc[0] !== etc) begin
                    n_bad++;
                    ok = 1'b0;
                    $display("FAIL wrap_div v=%0d k=%0d: q0=%h tc0=%b, required q0=%h tc0=%b",
                             v, k, q[7:0], tc[0], eq, etc);
                end
            end
        end
        en[0] = 1'b0;
        div = 8'd0;
        cyc();
    endtask

    task automatic test_saturate();
        logic [7:0] exp_q  [4] = '{8'hFE, 8'hFF, 8'hFF, 8'hFF};
        logic       exp_tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        div = 8'd0; mode[3:2] = 2'b01; up[1] = 1'b1;
        load_val[15:8] = 8'hFD; load[1] = 1'b1; en[1] = 1'b1;
        cyc();
        n_cmp++;
        if (q[15:8] !== 8'hFD || tc[1] !== 1'b0 || busy[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_load: q1=%h tc1=%b busy1=%b, required q1=fd tc1=0 busy1=1", q[15:8], tc[1], busy[1]);
        end
        load[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_cmp++;
            if (q[15:8] !== exp_q[i] || tc[1] !== exp_tc[i] || busy[1] !== 1'b1) begin
                n_bad++;
                $display("FAIL sat_step%0d: q1=%h tc1=%b busy1=%b, required q1=%h tc1=%b busy1=1",
                         i, q[15:8], tc[1], busy[1], exp_q[i], exp_tc[i]);
            end
        end
        en[1] = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [7:0] exp_q    [6] = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        logic       exp_tc   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       exp_busy [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        div = 8'd0; mode[5:4] = 2'b10; up[2] = 1'b0;
        load_val[23:16] = 8'd3; load[2] = 1'b1; en[2] = 1'b1;
        cyc();
        n_cmp++;
        if (q[23:16] !== 8'd3 || busy[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL os_load: q2=%h busy2=%b, required q2=03 busy2=1", q[23:16], busy[2]);
        end
        load[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            n_cmp++;
            if (q[23:16] !== exp_q[i] || tc[2] !== exp_tc[i] || busy[2] !== exp_busy[i]) begin
                n_bad++;
                $display("FAIL os_step%0d: q2=%h tc2=%b busy2=%b, required q2=%h tc2=%b busy2=%b",
                         i, q[23:16], tc[2], busy[2], exp_q[i], exp_tc[i], exp_busy[i]);
            end
        end
        load_val[23:16] = 8'd5; load[2] = 1'b1; en[2] = 1'b0;
        cyc();
        n_cmp++;
        if (q[23:16] !== 8'd5 || tc[2] !== 1'b0 || busy[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL os_reload: q2=%h tc2=%b busy2=%b, required q2=05 tc2=0 busy2=1", q[23:16], tc[2], busy[2]);
        end
        load[2] = 1'b0;
    endtask

    task automatic test_clr_load_step();
        div = 8'd0; mode[7:6] = 2'b00; up[3] = 1'b1;
        load_val[31:24] = 8'h10; load[3] = 1'b1; en[3] = 1'b1;
        cyc();
        n_cmp++;
        if (q[31:24] !== 8'h10 || busy[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL cls_setup: q3=%h busy3=%b, required q3=10 busy3=1", q[31:24], busy[3]);
        end
        clr[3] = 1'b1; load_val[31:24] = 8'h20;
        cyc();
        n_cmp++;
        if (q[31:24] !== 8'h00 || tc[3] !== 1'b0 || busy[3] !== 1'b0) begin
            n_bad++;
            $display("FAIL cls_clr_wins: q3=%h tc3=%b busy3=%b, required q3=00 tc3=0 busy3=0", q[31:24], tc[3], busy[3]);
        end
        clr[3] = 1'b0; en[3] = 1'b0; load_val[31:24] = 8'hFF;
        cyc();
        n_cmp++;
        if (q[31:24] !== 8'hFF || tc[3] !== 1'b0 || busy[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL cls_load_ff: q3=%h tc3=%b busy3=%b, required q3=ff tc3=0 busy3=1", q[31:24], tc[3], busy[3]);
        end
        load[3] = 1'b0; en[3] = 1'b1;
        cyc();
        n_cmp++;
        if (q[31:24] !== 8'h00 || tc[3] !== 1'b0) begin
            n_bad++;
            $display("FAIL cls_wrap0: q3=%h tc3=%b, required q3=00 tc3=0", q[31:24], tc[3]);
        end
        en[3] = 1'b0;
    endtask

    task automatic test_dir_flip();
        logic [7:0] exp_q  [3] = '{8'h00, 8'hFF, 8'hFE};
        logic       exp_tc [3] = '{1'b1, 1'b0, 1'b0};
        div = 8'd0; mode[1:0] = 2'b00; up[0] = 1'b1;
        load_val[7:0] = 8'h01; load[0] = 1'b1; en[0] = 1'b0;
        cyc();
        n_cmp++;
        if (q[7:0] !== 8'h01 || tc[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL flip_load: q0=%h tc0=%b, required q0=01 tc0=0", q[7:0], tc[0]);
        end
        load[0] = 1'b0; up[0] = 1'b0; en[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++;
            if (q[7:0] !== exp_q[i] || tc[0] !== exp_tc[i]) begin
                n_bad++;
                $display("FAIL flip_step%0d: q0=%h tc0=%b, required q0=%h tc0=%b",
                         i, q[7:0], tc[0], exp_q[i], exp_tc[i]);
            end
        end
        en[0] = 1'b0;
    endtask

    task automatic test_independence();
        cyc();
        n_cmp++;
        if (q[15:8] !== 8'hFF || busy[1] !== 1'b1 || q[23:16] !== 8'd5 || busy[2] !== 1'b1 || tc !== 4'h0) begin
            n_bad++;
            $display("FAIL independence: q1=%h busy1=%b q2=%h busy2=%b tc=%b, required q1=ff busy1=1 q2=05 busy2=1 tc=0",
                     q[15:8], busy[1], q[23:16], busy[2], tc);
        end
    endtask

    initial begin
        test_reset();
        test_wrap_div();
        test_saturate();
        test_oneshot();
        test_clr_load_step();
        test_dir_flip();
        test_independence();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
